booth_mul_pipe: RTL and testbench

//  Parametrised, pipelined radix-4 Booth multiplier for the M-extension execute stage.

---
 rtl/booth_mul_pkg.sv | 29 ++
 rtl/booth_pp_gen.sv | 37 +++
 rtl/booth_mul_pipe.sv | 129 ++++++++++++
 tb/tb_booth_mul_pipe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mul_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: RV32M op encodings,
// Booth digit type and the digit-count helper.
package booth_mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_e;

  // Operands are widened by two bits so the digit count stays integral for unsigned ops.
  function automatic int booth_digits(input int w);
    return (w + 2) / 2;
  endfunction

  function automatic booth_digit_e booth_decode(input logic [2:0] c);
    booth_digit_e d;
    case (c)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product: recodes a 3-bit window of the multiplier
// and produces the selected multiple of the multiplicand, shifted into place.
module booth_pp_gen
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHIFT = 0
) (
  input  logic [2:0]         code_i,
  input  logic [WIDTH+1:0]   a_i,
  output logic [2*WIDTH-1:0] pp_o
);

  booth_digit_e       dig;
  logic [2*WIDTH-1:0] a_sx, mag, sel;
  logic               neg;

  assign dig  = booth_decode(code_i);
  assign a_sx = {{(WIDTH-2){a_i[WIDTH+1]}}, a_i};

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (dig)
      POS1:    mag = a_sx;
      POS2:    mag = a_sx << 1;
      NEG1:    begin mag = a_sx;      neg = 1'b1; end
      NEG2:    begin mag = a_sx << 1; neg = 1'b1; end
      default: mag = '0;
    endcase
  end

  // Negation is exact two's complement; everything wraps mod 2^(2*WIDTH).
  assign sel  = neg ? (~mag + 1'b1) : mag;
  assign pp_o = sel << SHIFT;

endmodule

// File: rtl/booth_mul_pipe.sv
// Two-stage pipelined radix-4 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU
// with valid/ready on both sides. Define BOOTH_MUL_FLUSH_EN to add the flush port.
module booth_mul_pipe
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
`ifdef BOOTH_MUL_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag
);

  localparam int N  = booth_digits(WIDTH);
  localparam int XW = WIDTH + 2;
  localparam int PW = 2 * WIDTH;

  logic flush_w;
`ifdef BOOTH_MUL_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  logic s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  logic s1_adv, s2_adv, accept;

  assign s2_adv   = ~out_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv & ~flush_w;
  assign accept   = in_valid & in_ready;

  // Signedness per op: a is unsigned only for MULHU, b is signed only for MUL/MULH.
  logic          a_sgn, b_sgn;
  logic [XW-1:0] a_ext;
  logic [XW:0]   b_pad;

  assign a_sgn = (in_op != OP_MULHU) & in_a[WIDTH-1];
  assign b_sgn = ~in_op[1] & in_b[WIDTH-1];
  assign a_ext = {{2{a_sgn}}, in_a};
  assign b_pad = {{2{b_sgn}}, in_b, 1'b0};

  logic [N-1:0][PW-1:0] pp_d, pp_q;
  logic [1:0]           s1_op_q;
  logic [TAG_W-1:0]     s1_tag_q;

  for (genvar gi = 0; gi < N; gi++) begin : g_pp
    booth_pp_gen #(.WIDTH(WIDTH), .SHIFT(2*gi)) u_pp (
      .code_i (b_pad[2*gi+2 -: 3]),
      .a_i    (a_ext),
      .pp_o   (pp_d[gi])
    );
  end

  // 3:2 carry-save reduction: each level folds one more partial product in.
  logic [N-2:0][PW-1:0] cs_s, cs_c;
  logic [PW-1:0]        prod;
  logic [WIDTH-1:0]     res_d;

  assign cs_s[0] = pp_q[0];
  assign cs_c[0] = pp_q[1];
  for (genvar gi = 0; gi < N-2; gi++) begin : g_csa
    assign cs_s[gi+1] = cs_s[gi] ^ cs_c[gi] ^ pp_q[gi+2];
    assign cs_c[gi+1] = ((cs_s[gi] & cs_c[gi]) | (cs_s[gi] & pp_q[gi+2]) |
                         (cs_c[gi] & pp_q[gi+2])) << 1;
  end

  assign prod  = cs_s[N-2] + cs_c[N-2];
  assign res_d = (s1_op_q == OP_MUL) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];

  always_comb begin
    s1_valid_d  = accept | (s1_valid_q & ~s1_adv);
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    if (flush_w) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  logic [WIDTH-1:0] out_res_q;
  logic [TAG_W-1:0] out_tag_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pp_q      <= '0;
      s1_op_q   <= '0;
      s1_tag_q  <= '0;
      out_res_q <= '0;
      out_tag_q <= '0;
    end else begin
      if (accept) begin
        pp_q     <= pp_d;
        s1_op_q  <= in_op;
        s1_tag_q <= in_tag;
      end
      if (s2_adv & s1_valid_q) begin
        out_res_q <= res_d;
        out_tag_q <= s1_tag_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_booth_mul_pipe.sv
// Bench for booth_mul_pipe: directed RV32M cases plus a random stream scored
// against a plain 64-bit product model with an in-order expectation queue.
module tb_booth_mul_pipe;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b, out_res;
  logic [4:0]  in_tag, out_tag;
`ifdef BOOTH_MUL_FLUSH_EN
  logic        flush;
`endif

  booth_mul_pipe #(.WIDTH(32), .TAG_W(5)) dut (
`ifdef BOOTH_MUL_FLUSH_EN
    .flush     (flush),
`endif
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = (op == 2'b11) ? longint'({32'b0, a}) : longint'($signed(a));
    sb = op[1]         ? longint'({32'b0, b}) : longint'($signed(b));
    p  = 64'(sa * sb);
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Per-cycle scoreboard; inputs and out_ready are stable at the falling edge.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_res;
  logic [4:0]  prev_tag;

  always @(negedge CLK) begin
    if (!RST_N) begin
      q.delete();
      prev_hold = 1'b0;
    end
`ifdef BOOTH_MUL_FLUSH_EN
    else if (flush) begin
      chk("flush_in_ready", in_ready, 0);
      q.delete();
      prev_hold = 1'b0;
    end
`endif
    else begin
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      if (prev_hold) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_res", out_res, prev_res);
        chk("stall_tag", out_tag, prev_tag);
      end
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          chk("res", out_res, q[0].res);
          chk("tag", out_tag, q[0].tag);
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_hold = out_valid & ~out_ready;
      prev_res  = out_res;
      prev_tag  = out_tag;
      if (in_valid && in_ready) q.push_back('{ref_mul(in_op, in_a, in_b), in_tag});
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    bit acc = 1'b0;
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge CLK); acc = in_ready;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    chk("send_accept", acc, 1);
  endtask

  task automatic lat_chk(input string nm, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
    out_ready = 1'b1;
    send(op, a, b, tag);
    chk({nm, "_early"}, out_valid, 0);
    @(posedge CLK); #1;
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_res"}, out_res, exp);
    chk({nm, "_tag"}, out_tag, tag);
    @(posedge CLK); #1;
  endtask

  // mode 0: back-to-back ops, out_ready low for cycles 3..5; mode 1: random both sides.
  task automatic stream(input int nops, input int mode);
    int sent = 0;
    int cyc  = 0;
    bit acc;
    in_valid = 1'b0;
    while (sent < nops && cyc < 60000) begin
      if (!in_valid && (mode == 0 || $urandom_range(3) != 0)) begin
        in_op  = 2'($urandom_range(3));
        in_a   = rnd_opnd();
        in_b   = rnd_opnd();
        in_tag = 5'($urandom_range(31));
        in_valid = 1'b1;
      end
      out_ready = (mode == 0) ? !(cyc >= 3 && cyc < 6) : ($urandom_range(3) != 0);
      @(negedge CLK);
      acc = in_valid & in_ready;
      if (mode == 0 && cyc == 4) chk("full_in_ready", in_ready, 0);
      @(posedge CLK); #1;
      if (acc) begin sent++; in_valid = 1'b0; end
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_sent", sent, nops);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin @(posedge CLK); #1; end
    @(posedge CLK); #1;
    chk("drain_empty", q.size(), 0);
    chk("drain_valid", out_valid, 0);
  endtask

  initial begin
    RST_N = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;
`ifdef BOOTH_MUL_FLUSH_EN
    flush = 1'b0;
`endif

    chk("model_mul",    ref_mul(2'b00, 32'd7, 32'hFFFF_FFFD),         32'hFFFF_FFEB);
    chk("model_mulh",   ref_mul(2'b01, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    chk("model_mulhu",  ref_mul(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    chk("model_mulhsu", ref_mul(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge CLK); #3 RST_N = 1'b1;
    @(posedge CLK); #1;

    lat_chk("t1_mul",    2'b00, 32'd7, 32'hFFFF_FFFD,         5'd9,  32'hFFFF_FFEB);
    lat_chk("t2_mulh",   2'b01, 32'h8000_0000, 32'h8000_0000, 5'd17, 32'h4000_0000);
    lat_chk("t2_mulhu",  2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE);
    lat_chk("t3_mulhsu", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF);

    stream(8, 0);
    drain();

    out_ready = 1'b0;
    send(2'b00, 32'd11, 32'd13, 5'd1);
    send(2'b01, 32'd12, 32'd14, 5'd2);
    #2 RST_N = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_res", out_res, 0);
    @(posedge CLK); #3 RST_N = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge CLK);
    #1 chk("t5_no_stale", out_valid, 0);

`ifdef BOOTH_MUL_FLUSH_EN
    out_ready = 1'b0;
    send(2'b00, 32'd21, 32'd22, 5'd4);
    send(2'b00, 32'd23, 32'd24, 5'd5);
    flush = 1'b1;
    @(posedge CLK); #1 flush = 1'b0;
    chk("t6_flush_valid", out_valid, 0);
    lat_chk("t6_after_flush", 2'b00, 32'd5, 32'd5, 5'd6, 32'd25);
`endif

    stream(10000, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
